// File: rtl/gt_lane_pkg.sv
// Shared definitions for the GT TX lane arbiter: the K-words the lane emits,
// the K-ctrl pattern they carry, the arbiter FSM state type and a helper that
// builds the per-packet channel header.
package gt_lane_pkg;

  localparam logic [31:0] K_IDLE0     = 32'hff55_55bc;
  localparam logic [31:0] K_IDLE1     = 32'hffaa_aabc;
  localparam logic [7:0]  K_CH_HDR_LO = 8'h04;
  localparam logic [31:0] K_ABORT     = 32'hff00_05bc;
  localparam logic [3:0]  CTRL_K0     = 4'b0001;

  typedef enum logic [2:0] {
    IDLE0,
    IDLE1,
    HDR,
    PASS,
    ABORT
  } lane_state_e;

  // Channel header word: {ff, channel, 04, bc}, K-char in byte 0.
  function automatic logic [31:0] ch_header(input logic [7:0] ch);
    return {8'hff, ch, K_CH_HDR_LO, 8'hbc};
  endfunction

endpackage

// File: rtl/gt_tx_lane_arbiter_rr_arbiter.sv
// Round-robin search for the GT TX lane arbiter.
// Ports:
//   req      in  N   request vector
//   last_ptr in  IW  index of the previous winner; search starts one above it
//   gnt      out N   one-hot winner (all zero when no request)
//   idx      out IW  index of the winner
//   any      out 1   at least one request present
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned cand;

  // Walk last_ptr+1 .. last_ptr+N (mod N); the first requester found wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last_ptr) + off) % N;
      if (!any && req[IW'(cand)]) begin
        any               = 1'b1;
        idx               = IW'(cand);
        gnt[IW'(cand)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gt_tx_lane_arbiter.sv
// Shares one GT TX lane (32b data + 4b K-ctrl) between N_CH packet sources.
// Round-robin grant at packet boundaries, idle K-words between packets, a
// channel header in front of every packet and an abort word when the granted
// source stalls for TIMEOUT cycles.
// Ports:
//   tx_clk       in   lane clock, rising edge
//   rst          in   synchronous active-high reset
//   src_req      in   N_CH     per-source packet pending
//   src_valid    in   N_CH     per-source word valid
//   src_last     in   N_CH     per-source last word of packet
//   src_data     in   32*N_CH  per-source data, source i at [32i+31:32i]
//   src_ctrl     in   4*N_CH   per-source K-ctrl, source i at [4i+3:4i]
//   src_gnt      out  N_CH     one-hot grant held for the whole packet
//   src_rdy      out  N_CH     word of source i accepted when rdy & valid
//   gt_tx_data   out  32       registered lane data
//   gt_tx_ctrl   out  4        registered lane K-ctrl
//   abort_pulse  out  1        high for the cycle the abort word is on the lane
module gt_tx_lane_arbiter
  import gt_lane_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned MIN_IDLE = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                tx_clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     src_req,
  input  logic [N_CH-1:0]     src_valid,
  input  logic [N_CH-1:0]     src_last,
  input  logic [32*N_CH-1:0]  src_data,
  input  logic [4*N_CH-1:0]   src_ctrl,
  output logic [N_CH-1:0]     src_gnt,
  output logic [N_CH-1:0]     src_rdy,
  output logic [31:0]         gt_tx_data,
  output logic [3:0]          gt_tx_ctrl,
  output logic                abort_pulse
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = $clog2(MIN_IDLE + 1);

  lane_state_e     state_q, state_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            abort_q, abort_d;

  logic [N_CH-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [31:0]     sel_data;
  logic [3:0]      sel_ctrl;
  logic            sel_valid;
  logic            sel_last;

  rr_arbiter #(
    .N  (N_CH),
    .IW (IW)
  ) u_rr (
    .req      (src_req),
    .last_ptr (rr_last_q),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  // Granted source's lane signals.
  always_comb begin
    sel_data  = '0;
    sel_ctrl  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_q == IW'(i)) begin
        sel_data  = src_data[32*i +: 32];
        sel_ctrl  = src_ctrl[4*i +: 4];
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
      end
    end
  end

  // Ready only while passing data, and only for the granted source.
  always_comb begin
    src_rdy = (state_q == PASS) ? gnt_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ch_d        = ch_q;
    rr_last_d   = rr_last_q;
    idle_cnt_d  = idle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    data_d      = K_IDLE0;
    ctrl_d      = CTRL_K0;
    abort_d     = 1'b0;

    case (state_q)
      IDLE0: begin
        data_d  = K_IDLE0;
        state_d = IDLE1;
        if (idle_cnt_q < CW'(MIN_IDLE)) idle_cnt_d = idle_cnt_q + 1'b1;
      end
      IDLE1: begin
        data_d = K_IDLE1;
        if (idle_cnt_q < CW'(MIN_IDLE)) idle_cnt_d = idle_cnt_q + 1'b1;
        // The gap check uses the count before this word, so the gap after a
        // packet always contains at least MIN_IDLE idle words.
        if (idle_cnt_q >= CW'(MIN_IDLE) && arb_any) begin
          state_d   = HDR;
          ch_d      = arb_idx;
          rr_last_d = arb_idx;
          gnt_d     = arb_gnt;
        end else begin
          state_d = IDLE0;
        end
      end
      HDR: begin
        data_d      = ch_header(8'(ch_q));
        stall_cnt_d = '0;
        state_d     = PASS;
      end
      PASS: begin
        if (sel_valid) begin
          data_d      = sel_data;
          ctrl_d      = sel_ctrl;
          stall_cnt_d = '0;
          if (sel_last) begin
            state_d    = IDLE0;
            gnt_d      = '0;
            idle_cnt_d = '0;
          end
        end else begin
          data_d = K_IDLE0;
          if (stall_cnt_q == SW'(TIMEOUT - 1)) begin
            state_d = ABORT;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      ABORT: begin
        data_d  = K_ABORT;
        abort_d = 1'b1;
        gnt_d   = '0;
        state_d = IDLE0;
      end
      default: begin
        state_d = IDLE0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q     <= IDLE0;
      gnt_q       <= '0;
      ch_q        <= '0;
      rr_last_q   <= IW'(N_CH - 1);
      idle_cnt_q  <= '0;
      stall_cnt_q <= '0;
      data_q      <= K_IDLE0;
      ctrl_q      <= CTRL_K0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ch_q        <= ch_d;
      rr_last_q   <= rr_last_d;
      idle_cnt_q  <= idle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      abort_q     <= abort_d;
    end
  end

  assign src_gnt     = gnt_q;
  assign gt_tx_data  = data_q;
  assign gt_tx_ctrl  = ctrl_q;
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_gt_tx_lane_arbiter.sv
// Bench for gt_tx_lane_arbiter (2 channels, MIN_IDLE=2, TIMEOUT=16).
module tb_gt_tx_lane_arbiter;

  localparam logic [31:0] W_I0  = 32'hff55_55bc;
  localparam logic [31:0] W_I1  = 32'hffaa_aabc;
  localparam logic [31:0] W_AB  = 32'hff00_05bc;
  localparam logic [31:0] W_H0  = 32'hff00_04bc;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src_req, src_valid, src_last, src_gnt, src_rdy;
  logic [63:0] src_data;
  logic [7:0]  src_ctrl;
  logic [31:0] gt_tx_data;
  logic [3:0]  gt_tx_ctrl;
  logic        abort_pulse;

  gt_tx_lane_arbiter #(
    .N_CH     (2),
    .MIN_IDLE (2),
    .TIMEOUT  (16)
  ) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .src_req     (src_req),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .src_data    (src_data),
    .src_ctrl    (src_ctrl),
    .src_gnt     (src_gnt),
    .src_rdy     (src_rdy),
    .gt_tx_data  (gt_tx_data),
    .gt_tx_ctrl  (gt_tx_ctrl),
    .abort_pulse (abort_pulse)
  );

  always #5 tx_clk = ~tx_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  typedef struct {
    logic        req0;
    logic        valid0;
    logic        last0;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic [3:0]  exp_ctrl;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic l,
                              input logic [31:0] din, input logic [31:0] ed,
                              input logic [3:0] ec, input logic [1:0] eg,
                              input logic [1:0] er);
    vec_t t;
    t.req0 = r; t.valid0 = v; t.last0 = l; t.din = din;
    t.exp_data = ed; t.exp_ctrl = ec; t.exp_gnt = eg; t.exp_rdy = er;
    return t;
  endfunction

  // Source model + lane scoreboard state.
  int unsigned plen[2], npkt[2], widx[2], pktn[2];
  int unsigned stall_from[2], stall_len[2], stall_left[2];
  bit          stall_rep[2], hang[2];
  logic [31:0] expq[$];
  int unsigned hdr_log[$];
  int unsigned n_abort, fill_cnt;

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      plen[i] = 2; npkt[i] = 0; widx[i] = 0; pktn[i] = 0;
      stall_from[i] = 0; stall_len[i] = 0; stall_left[i] = 0;
      stall_rep[i] = 1'b0; hang[i] = 1'b0;
    end
    expq.delete();
    hdr_log.delete();
    n_abort = 0;
    fill_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req = '0; src_valid = '0; src_last = '0; src_data = '0; src_ctrl = '0;
    step();
    step();
    rst = 1'b0;
    clear_model();
  endtask

  // One lane cycle: check what is on the lane now, then drive the sources.
  task automatic cycle();
    chk("gnt_onehot0", 32'($onehot0(src_gnt)), 32'd1);
    if (gt_tx_ctrl == 4'b0000) begin
      if (expq.size() == 0) chk("extra_word", 32'(expq.size()), 32'd1);
      else chk("lane_data", gt_tx_data, expq.pop_front());
    end else if (gt_tx_data[31:24] == 8'hff && gt_tx_data[15:0] == 16'h04bc) begin
      hdr_log.push_back(32'(gt_tx_data[23:16]));
    end
    if (abort_pulse) begin
      n_abort++;
      chk("abort_word", gt_tx_data, W_AB);
    end
    if (gt_tx_data == W_I0 && src_gnt != 2'b00) fill_cnt++;

    for (int i = 0; i < 2; i++) begin
      logic [31:0] d;
      logic v, l;
      d = {4'hc, 4'(i), 8'(pktn[i]), 16'(widx[i])};
      l = (widx[i] == plen[i] - 1);
      v = (npkt[i] != 0) && !hang[i];
      if (v && src_rdy[i] && stall_left[i] != 0 && widx[i] >= stall_from[i]) begin
        v = 1'b0;
        stall_left[i]--;
      end
      src_req[i]          = (npkt[i] != 0);
      src_valid[i]        = v;
      src_last[i]         = l & v;
      src_data[32*i +: 32] = d;
      src_ctrl[4*i +: 4]  = 4'h0;
      if (v && src_rdy[i]) begin
        expq.push_back(d);
        if (stall_rep[i]) stall_left[i] = stall_len[i];
        if (l) begin
          widx[i] = 0;
          pktn[i]++;
          npkt[i]--;
        end else begin
          widx[i]++;
        end
      end
    end
    step();
  endtask

  task automatic run_until_drained(input string name, input int budget);
    int k;
    k = 0;
    while ((npkt[0] != 0 || npkt[1] != 0 || expq.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    chk({name, "_drained"}, 32'(npkt[0] + npkt[1] + expq.size()), 32'd0);
  endtask

  initial begin
    // Reset/idle alternation, then one 4-word packet from ch0.
    for (int r = 0; r < 10; r++)
      vecs.push_back(mk(0, 0, 0, 32'h0, (r >= 2 && r % 2 == 0) ? W_I1 : W_I0, 4'b0001, 2'b00, 2'b00));
    vecs.push_back(mk(1, 0, 0, 32'h0,          W_I1,         4'b0001, 2'b00, 2'b00));
    vecs.push_back(mk(1, 0, 0, 32'h0,          W_I0,         4'b0001, 2'b00, 2'b00));
    vecs.push_back(mk(1, 0, 0, 32'h0,          W_I1,         4'b0001, 2'b01, 2'b00));
    vecs.push_back(mk(1, 1, 0, 32'hA0A0_0000,  W_H0,         4'b0001, 2'b01, 2'b01));
    vecs.push_back(mk(1, 1, 0, 32'hA1A1_1111,  32'hA0A0_0000, 4'b0000, 2'b01, 2'b01));
    vecs.push_back(mk(1, 1, 0, 32'hA2A2_2222,  32'hA1A1_1111, 4'b0000, 2'b01, 2'b01));
    vecs.push_back(mk(1, 1, 1, 32'hA3A3_3333,  32'hA2A2_2222, 4'b0000, 2'b01, 2'b01));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'hA3A3_3333, 4'b0000, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 0, 32'h0,          W_I0,         4'b0001, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 0, 32'h0,          W_I1,         4'b0001, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 0, 32'h0,          W_I0,         4'b0001, 2'b00, 2'b00));

    do_reset();
    for (int r = 0; r < vecs.size(); r++) begin
      src_req   = {1'b0, vecs[r].req0};
      src_valid = {1'b0, vecs[r].valid0};
      src_last  = {1'b0, vecs[r].last0};
      src_data  = {32'h0, vecs[r].din};
      src_ctrl  = '0;
      chk($sformatf("v%0d_data", r),  gt_tx_data,  vecs[r].exp_data);
      chk($sformatf("v%0d_ctrl", r),  gt_tx_ctrl,  vecs[r].exp_ctrl);
      chk($sformatf("v%0d_gnt", r),   src_gnt,     vecs[r].exp_gnt);
      chk($sformatf("v%0d_rdy", r),   src_rdy,     vecs[r].exp_rdy);
      chk($sformatf("v%0d_abort", r), abort_pulse, 1'b0);
      step();
    end

    // Both channels requesting continuously: headers alternate 0,1,0,1.
    do_reset();
    npkt[0] = 2; npkt[1] = 2;
    run_until_drained("rr", 300);
    chk("rr_hdr_count", 32'(hdr_log.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < hdr_log.size()) chk($sformatf("rr_hdr%0d", j), hdr_log[j], 32'(j % 2));

    // Ch1 stalls 3 cycles mid-packet: 3 fillers, data intact.
    do_reset();
    npkt[1] = 1; plen[1] = 5; stall_from[1] = 2; stall_left[1] = 3;
    run_until_drained("stall3", 200);
    chk("stall3_fillers", fill_cnt, 32'd3);
    chk("stall3_aborts", n_abort, 32'd0);
    chk("stall3_hdr_ch", (hdr_log.size() == 1) ? hdr_log[0] : 32'hffff_ffff, 32'd1);

    // Two 10-cycle stalls in one packet: no abort since stall count restarts per word.
    do_reset();
    npkt[0] = 1; plen[0] = 3; stall_from[0] = 1; stall_len[0] = 10;
    stall_left[0] = 10; stall_rep[0] = 1'b1;
    run_until_drained("stall10", 200);
    chk("stall10_fillers", fill_cnt, 32'd20);
    chk("stall10_aborts", n_abort, 32'd0);

    // Ch0 hangs: 16 fillers then abort; pending ch1 served next.
    do_reset();
    npkt[0] = 1; hang[0] = 1'b1; npkt[1] = 1; plen[1] = 2;
    for (int k = 0; k < 100 && n_abort == 0; k++) cycle();
    chk("to_abort_seen", n_abort, 32'd1);
    chk("to_fillers", fill_cnt, 32'd16);
    npkt[0] = 0; hang[0] = 1'b0;
    run_until_drained("to", 100);
    for (int k = 0; k < 6; k++) cycle();
    chk("to_abort_once", n_abort, 32'd1);
    chk("to_hdr_count", 32'(hdr_log.size()), 32'd2);
    if (hdr_log.size() == 2) begin
      chk("to_hdr0", hdr_log[0], 32'd0);
      chk("to_hdr1", hdr_log[1], 32'd1);
    end

    // Reset mid-packet: grant dropped at once, ch0 first afterwards.
    do_reset();
    npkt[0] = 1; plen[0] = 8;
    for (int k = 0; k < 50 && !(src_rdy[0] && widx[0] == 3); k++) cycle();
    chk("rst_reached_pass", 32'(src_rdy[0] && widx[0] == 3), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_gnt", src_gnt, 2'b00);
    chk("rst_rdy", src_rdy, 2'b00);
    chk("rst_data", gt_tx_data, W_I0);
    chk("rst_ctrl", gt_tx_ctrl, 4'b0001);
    chk("rst_abort", abort_pulse, 1'b0);
    rst = 1'b0;
    clear_model();
    npkt[0] = 1; npkt[1] = 1;
    for (int k = 0; k < 40 && hdr_log.size() == 0; k++) cycle();
    chk("rst_first_hdr", (hdr_log.size() != 0) ? hdr_log[0] : 32'hffff_ffff, 32'd0);
    run_until_drained("rst", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
